exec_share_arbiter: RTL and testbench
=====================================

# exec_share_arbiter

Sequencer that time-shares one `execution_unit` instance between two requesters: requester 0 is the core decode stage and requester 1 is the debug/self-test port. Each requester uses a valid/ready handshake. The block latches the winning operation, drives the execution unit for one cycle and captures the registered result. It holds the response until the owning requester accepts it. It sits between decode, debug and the execution unit, replacing the direct decode-to-execute wiring.

## Interface
- `CORE`, 0, core ID passed through to the execution unit.
- `DATA_WIDTH`, 32, operand/result width.
- `ADDRESS_BITS`, 20, PC and JALR-target width.

Ports. Index `i` selects the requester; vectors are packed `{req1,req0}`.
- `clk` in 1: single clock.
- `reset` in 1: active-low, asynchronous reset.
- `req_valid` in 2: requester i presents an operation.
- `req_ready` out 2: one-hot accept pulse, one cycle.
- `req_alu_op` in 2x3: ALU_Operation.
- `req_funct3` in 2x3, `req_funct7` in 2x7.
- `req_pc` in 2xADDRESS_BITS.
- `req_asrc` in 2x2: ALU A-source select.
- `req_bsrc` in 2x1: ALU B-source select.
- `req_branch_op` in 2x1.
- `req_rs1`, `req_rs2`, `req_ext` in 2xDATA_WIDTH.
- `rsp_valid` out 2: one-hot, result available to requester i.
- `rsp_ready` in 2: requester i consumes the result.
- `rsp_result` out DATA_WIDTH.
- `rsp_zero` out 1, `rsp_branch` out 1.
- `rsp_jalr_target` out ADDRESS_BITS.
- `ex_*` out: registered operation fields driven to the `execution_unit` (same widths as the `req_*` fields).
- `ex_result`, `ex_zero`, `ex_branch`, `ex_jalr_target` in: combinational outputs of the `execution_unit`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- **IDLE**
  - If any `req_valid` is high, pick a winner with a 2-way round-robin.
  - Priority pointer `prio` starts at 0. If both requesters are valid, the one `prio` indicates wins. If only one is valid, it wins regardless of `prio`.
  - Assert `req_ready[win]` combinationally and latch all of its fields into the `op_*` registers. Record the winner in `owner`. Go to ISSUE.
- **ISSUE**
  - `ex_*` reflects the `op_*` registers.
  - At the end of the cycle, capture `ex_result`, `ex_zero`, `ex_branch` and `ex_jalr_target` into the `rsp_*` registers. Go to RESP.
- **RESP**
  - `rsp_valid[owner]` is high.
  - When `rsp_ready[owner]` is high, set `prio <= ~owner` and go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- Requester rule: fields must be held stable while `req_valid` is high and `req_ready` is low. The block never drops an accepted operation except on reset.
- `ex_*` holds its last values outside ISSUE, which prevents spurious toggling.
- No arithmetic is performed here; all fields pass through unmodified and widths are identical end to end.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `prio`=0, `owner`=0, `req_ready`=0, `rsp_valid`=0, `busy`=0. All `rsp_*`, `op_*` and `ex_*` registers are 0.
- Latency: accept at edge N (the `req_ready` cycle), then ISSUE during cycle N+1, then `rsp_valid` high from cycle N+2.
- Maximum throughput: one operation per 3 cycles, with `rsp_ready` already high during RESP.
- A request arriving during ISSUE or RESP waits; `req_ready` is low outside IDLE.
- A back-to-back request from the same requester is accepted on the cycle after its RESP handshake. The other requester wins that cycle if it is valid.
- Reset asserted mid-operation: the operation is discarded, `rsp_valid` falls immediately and no response is ever issued.
- `rsp_*` data is stable for the whole RESP state.

## Structure
- Package `exec_arb_pkg`:
  - State enum `{IDLE, ISSUE, RESP}`, 2-bit encoding.
  - Constants `NUM_REQ`=2, `ALU_OP_W`=3, `F3_W`=3, `F7_W`=7, `ASRC_W`=2.
- Sub-module `rr_arb2`: inputs `valid[1:0]` and `prio`; output one-hot `grant[1:0]`; purely combinational.
- The `execution_unit` is instantiated by the parent, not inside this block.

## Test plan
- **Single requester, shift:** req0 sends op 000, funct3 101, funct7 0000000, asrc 0, bsrc 0, rs1=5, rs2=7. Expect `req_ready`=01 for one cycle, `rsp_valid`=01 two cycles later, `rsp_result`=0 (SRL 5>>7), `rsp_zero`=1.
- **Single requester, subtract:** req1 sends op 000, funct3 000, funct7 0100000, rs1=5, rs2=7. Expect `rsp_valid`=10 and `rsp_result`=32'hFFFF_FFFE.
- **Simultaneous requests:** both requesters valid from reset; req0 performs ADD 5+7, req1 performs ADD 1+2. Expect grants 01 then 10, results 12 then 3, and `prio`=0 after the second response.
- **Response backpressure:** hold `rsp_ready[owner]` low for 5 cycles. Expect `rsp_valid` and `rsp_result` stable, `req_ready`=00 and `busy`=1 throughout, then return to IDLE one edge after `rsp_ready` rises.
- **Reset mid-operation:** assert `reset`=0 during ISSUE. Expect all outputs to be 0 immediately. After release, the first grant goes to req0 when both requesters are valid.
- **Non-owner ready ignored:** `rsp_ready[1]` high while req0 owns the response. Expect the state to stay RESP until `rsp_ready[0]` rises.

Source files
------------

// File: rtl/exec_arb_pkg.sv
// Shared types and field widths for the execution-unit share arbiter.
package exec_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int NUM_REQ  = 2;
  localparam int ALU_OP_W = 3;
  localparam int F3_W     = 3;
  localparam int F7_W     = 7;
  localparam int ASRC_W   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone valid always wins, a tie goes to prio.
module rr_arb2
  import exec_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               prio,
  output logic [NUM_REQ-1:0] grant
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = valid[gi] & (~valid[NUM_REQ-1-gi] | (prio == 1'(gi)));
  end

endmodule

// File: rtl/exec_share_arbiter.sv
// Time-shares one execution unit between the decode stage (req 0) and the
// debug/self-test port (req 1): accept, issue for one cycle, hold the response.
module exec_share_arbiter
  import exec_arb_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]       req_alu_op,
  input  logic [NUM_REQ-1:0][F3_W-1:0]           req_funct3,
  input  logic [NUM_REQ-1:0][F7_W-1:0]           req_funct7,
  input  logic [NUM_REQ-1:0][ADDRESS_BITS-1:0]   req_pc,
  input  logic [NUM_REQ-1:0][ASRC_W-1:0]         req_asrc,
  input  logic [NUM_REQ-1:0]                     req_bsrc,
  input  logic [NUM_REQ-1:0]                     req_branch_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_rs1,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_rs2,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_ext,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  input  logic [NUM_REQ-1:0]                     rsp_ready,
  output logic [DATA_WIDTH-1:0]                  rsp_result,
  output logic                                   rsp_zero,
  output logic                                   rsp_branch,
  output logic [ADDRESS_BITS-1:0]                rsp_jalr_target,
  output logic [31:0]                            ex_core,
  output logic [ALU_OP_W-1:0]                    ex_alu_op,
  output logic [F3_W-1:0]                        ex_funct3,
  output logic [F7_W-1:0]                        ex_funct7,
  output logic [ADDRESS_BITS-1:0]                ex_pc,
  output logic [ASRC_W-1:0]                      ex_asrc,
  output logic                                   ex_bsrc,
  output logic                                   ex_branch_op,
  output logic [DATA_WIDTH-1:0]                  ex_rs1,
  output logic [DATA_WIDTH-1:0]                  ex_rs2,
  output logic [DATA_WIDTH-1:0]                  ex_ext,
  input  logic [DATA_WIDTH-1:0]                  ex_result,
  input  logic                                   ex_zero,
  input  logic                                   ex_branch,
  input  logic [ADDRESS_BITS-1:0]                ex_jalr_target,
  output logic                                   busy
);

  state_t                  state_reg;
  logic                    prio_reg;
  logic                    owner_reg;
  logic                    busy_reg;
  logic [NUM_REQ-1:0]      rsp_valid_reg;
  logic [NUM_REQ-1:0]      grant;
  logic                    win;

  logic [ALU_OP_W-1:0]     op_alu_op_reg;
  logic [F3_W-1:0]         op_funct3_reg;
  logic [F7_W-1:0]         op_funct7_reg;
  logic [ADDRESS_BITS-1:0] op_pc_reg;
  logic [ASRC_W-1:0]       op_asrc_reg;
  logic                    op_bsrc_reg;
  logic                    op_branch_op_reg;
  logic [DATA_WIDTH-1:0]   op_rs1_reg;
  logic [DATA_WIDTH-1:0]   op_rs2_reg;
  logic [DATA_WIDTH-1:0]   op_ext_reg;

  logic [DATA_WIDTH-1:0]   rsp_result_reg;
  logic                    rsp_zero_reg;
  logic                    rsp_branch_reg;
  logic [ADDRESS_BITS-1:0] rsp_jalr_target_reg;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio_reg),
    .grant (grant)
  );

  assign win = grant[1];
  // Gated by reset as well so no accept pulse is shown while held in reset.
  assign req_ready = (state_reg == IDLE && reset) ? grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg           <= IDLE;
      prio_reg            <= 1'b0;
      owner_reg           <= 1'b0;
      busy_reg            <= 1'b0;
      rsp_valid_reg       <= '0;
      op_alu_op_reg       <= '0;
      op_funct3_reg       <= '0;
      op_funct7_reg       <= '0;
      op_pc_reg           <= '0;
      op_asrc_reg         <= '0;
      op_bsrc_reg         <= 1'b0;
      op_branch_op_reg    <= 1'b0;
      op_rs1_reg          <= '0;
      op_rs2_reg          <= '0;
      op_ext_reg          <= '0;
      rsp_result_reg      <= '0;
      rsp_zero_reg        <= 1'b0;
      rsp_branch_reg      <= 1'b0;
      rsp_jalr_target_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            op_alu_op_reg    <= req_alu_op[win];
            op_funct3_reg    <= req_funct3[win];
            op_funct7_reg    <= req_funct7[win];
            op_pc_reg        <= req_pc[win];
            op_asrc_reg      <= req_asrc[win];
            op_bsrc_reg      <= req_bsrc[win];
            op_branch_op_reg <= req_branch_op[win];
            op_rs1_reg       <= req_rs1[win];
            op_rs2_reg       <= req_rs2[win];
            op_ext_reg       <= req_ext[win];
            owner_reg        <= win;
            busy_reg         <= 1'b1;
            state_reg        <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_result_reg      <= ex_result;
          rsp_zero_reg        <= ex_zero;
          rsp_branch_reg      <= ex_branch;
          rsp_jalr_target_reg <= ex_jalr_target;
          rsp_valid_reg       <= 2'b01 << owner_reg;
          state_reg           <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg <= '0;
            busy_reg      <= 1'b0;
            prio_reg      <= ~owner_reg;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The op registers only change on accept, so ex_* stays quiet outside ISSUE.
  assign ex_core         = 32'(CORE);
  assign ex_alu_op       = op_alu_op_reg;
  assign ex_funct3       = op_funct3_reg;
  assign ex_funct7       = op_funct7_reg;
  assign ex_pc           = op_pc_reg;
  assign ex_asrc         = op_asrc_reg;
  assign ex_bsrc         = op_bsrc_reg;
  assign ex_branch_op    = op_branch_op_reg;
  assign ex_rs1          = op_rs1_reg;
  assign ex_rs2          = op_rs2_reg;
  assign ex_ext          = op_ext_reg;

  assign rsp_valid       = rsp_valid_reg;
  assign rsp_result      = rsp_result_reg;
  assign rsp_zero        = rsp_zero_reg;
  assign rsp_branch      = rsp_branch_reg;
  assign rsp_jalr_target = rsp_jalr_target_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_exec_share_arbiter.sv
// Directed bench for exec_share_arbiter with a stand-in execution unit and a
// transaction-level model checked every cycle.
module tb_exec_share_arbiter;
  import exec_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 20;

  typedef struct packed {
    logic [2:0]    alu_op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [AW-1:0] pc;
    logic [1:0]    asrc;
    logic          bsrc;
    logic          br;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] ext;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  op_t  [1:0] req_op;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][2:0]    req_alu_op, req_funct3;
  logic [1:0][6:0]    req_funct7;
  logic [1:0][AW-1:0] req_pc;
  logic [1:0][1:0]    req_asrc;
  logic [1:0]         req_bsrc, req_branch_op;
  logic [1:0][DW-1:0] req_rs1, req_rs2, req_ext;

  logic [DW-1:0] rsp_result, ex_result, ex_rs1, ex_rs2, ex_ext;
  logic          rsp_zero, rsp_branch, ex_zero, ex_branch, ex_bsrc, ex_branch_op, busy;
  logic [AW-1:0] rsp_jalr_target, ex_jalr_target, ex_pc;
  logic [31:0]   ex_core;
  logic [2:0]    ex_alu_op, ex_funct3;
  logic [6:0]    ex_funct7;
  logic [1:0]    ex_asrc;
  op_t           ex_op;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_alu_op[gi]    = req_op[gi].alu_op;
    assign req_funct3[gi]    = req_op[gi].f3;
    assign req_funct7[gi]    = req_op[gi].f7;
    assign req_pc[gi]        = req_op[gi].pc;
    assign req_asrc[gi]      = req_op[gi].asrc;
    assign req_bsrc[gi]      = req_op[gi].bsrc;
    assign req_branch_op[gi] = req_op[gi].br;
    assign req_rs1[gi]       = req_op[gi].rs1;
    assign req_rs2[gi]       = req_op[gi].rs2;
    assign req_ext[gi]       = req_op[gi].ext;
  end

  exec_share_arbiter #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_pc(req_pc), .req_asrc(req_asrc), .req_bsrc(req_bsrc),
    .req_branch_op(req_branch_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ext(req_ext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_branch(rsp_branch), .rsp_jalr_target(rsp_jalr_target),
    .ex_core(ex_core), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_pc(ex_pc), .ex_asrc(ex_asrc), .ex_bsrc(ex_bsrc), .ex_branch_op(ex_branch_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ext(ex_ext),
    .ex_result(ex_result), .ex_zero(ex_zero), .ex_branch(ex_branch),
    .ex_jalr_target(ex_jalr_target), .busy(busy)
  );

  // Stand-in execution unit: small RV32-style ALU.
  function automatic logic [DW-1:0] alu(input op_t o);
    logic [DW-1:0] a, b;
    a = (o.asrc == 2'd0) ? o.rs1 : (o.asrc == 2'd1) ? 32'(o.pc) : '0;
    b = o.bsrc ? o.ext : o.rs2;
    if (o.alu_op != 3'd0) return a + b;
    case (o.f3)
      3'd0:    return o.f7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return o.f7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign ex_op          = {ex_alu_op, ex_funct3, ex_funct7, ex_pc, ex_asrc, ex_bsrc,
                           ex_branch_op, ex_rs1, ex_rs2, ex_ext};
  assign ex_result      = alu(ex_op);
  assign ex_zero        = (ex_result == '0);
  assign ex_branch      = ex_branch_op & ex_zero;
  assign ex_jalr_target = AW'(ex_rs1 + ex_ext);

  function automatic op_t mk_op(input logic [2:0] alu_op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [AW-1:0] pc,
                                input logic [1:0] asrc, input logic bsrc, input logic br,
                                input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                                input logic [DW-1:0] ext);
    return '{alu_op: alu_op, f3: f3, f7: f7, pc: pc, asrc: asrc, bsrc: bsrc,
             br: br, rs1: rs1, rs2: rs2, ext: ext};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Transaction model: idle/occupied, cycles since accept, owner, priority.
  logic m_busy = 1'b0, m_owner = 1'b0, m_prio = 1'b0;
  int   m_age = 0;
  op_t  m_op = '0;

  always @(negedge clk) begin
    logic [1:0]    exp_rdy, exp_rv;
    logic [DW-1:0] exp_res;
    if (!reset) begin
      m_busy = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_age = 0;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_ex_op", ex_op, 0);
    end else begin
      exp_rdy = m_busy ? 2'b00 : pick(req_valid, m_prio);
      exp_rv  = (m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("mdl_req_ready", req_ready, exp_rdy);
      chk("mdl_rsp_valid", rsp_valid, exp_rv);
      chk("mdl_busy", busy, m_busy);
      if (m_busy && m_age == 1) chk("mdl_ex_fields", ex_op, m_op);
      if (exp_rv != 2'b00) begin
        exp_res = alu(m_op);
        chk("mdl_rsp_result", rsp_result, exp_res);
        chk("mdl_rsp_zero", rsp_zero, exp_res == '0);
        chk("mdl_rsp_branch", rsp_branch, m_op.br && exp_res == '0);
        chk("mdl_rsp_jalr", rsp_jalr_target, AW'(m_op.rs1 + m_op.ext));
      end
      if (!m_busy && exp_rdy != 2'b00) begin
        m_busy = 1'b1; m_owner = exp_rdy[1]; m_age = 1; m_op = req_op[exp_rdy[1]];
      end else if (m_busy && m_age == 1) begin
        m_age = 2;
      end else if (m_busy && rsp_ready[m_owner]) begin
        m_busy = 1'b0; m_prio = ~m_owner;
      end
    end
  end

  task automatic wait_grant(input logic [1:0] exp, input string name);
    int n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk({name, "_grant"}, req_ready, exp);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) if (exp[i]) req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input logic [1:0] exp, input logic [DW-1:0] res,
                          input string name, output int lat);
    lat = 0;
    while (rsp_valid == 2'b00 && lat < 20) begin @(negedge clk); lat++; end
    chk({name, "_rsp_valid"}, rsp_valid, exp);
    chk({name, "_result"}, rsp_result, res);
  endtask

  op_t add57, add12, srl_op, sub_op, xor_op, and_op, pc_op;
  int  lat;

  initial begin
    add57  = mk_op(3'd0, 3'd0, 7'h00, 20'h0,   2'd0, 1'b0, 1'b0, 32'd5,    32'd7,    32'd0);
    add12  = mk_op(3'd0, 3'd0, 7'h00, 20'h0,   2'd0, 1'b0, 1'b0, 32'd1,    32'd2,    32'd0);
    srl_op = mk_op(3'd0, 3'd5, 7'h00, 20'h0,   2'd0, 1'b0, 1'b0, 32'd5,    32'd7,    32'd0);
    sub_op = mk_op(3'd0, 3'd0, 7'h20, 20'h0,   2'd0, 1'b0, 1'b1, 32'd5,    32'd7,    32'd0);
    xor_op = mk_op(3'd0, 3'd4, 7'h00, 20'h0,   2'd0, 1'b0, 1'b0, 32'hF0,   32'h0F,   32'd0);
    and_op = mk_op(3'd0, 3'd7, 7'h00, 20'h0,   2'd0, 1'b1, 1'b1, 32'hFF,   32'd0,    32'h0F);
    pc_op  = mk_op(3'd1, 3'd0, 7'h00, 20'h100, 2'd1, 1'b1, 1'b0, 32'h2000, 32'd0,    32'd4);

    // Both requesters valid straight out of reset.
    req_op[0] = add57; req_op[1] = add12;
    req_valid = 2'b11; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_grant(2'b01, "sim0");
    wait_rsp(2'b01, 32'd12, "sim0", lat);
    wait_grant(2'b10, "sim1");
    wait_rsp(2'b10, 32'd3, "sim1", lat);
    // After req1's response prio points at req0 again.
    req_op[0] = add57; req_op[1] = add12; req_valid = 2'b11;
    wait_grant(2'b01, "prio0");
    wait_rsp(2'b01, 32'd12, "prio0", lat);
    wait_grant(2'b10, "prio1");
    wait_rsp(2'b10, 32'd3, "prio1", lat);

    // Single requester: shift right, then subtract from the debug port.
    @(posedge clk); #1;
    req_op[0] = srl_op; req_valid[0] = 1'b1;
    wait_grant(2'b01, "srl");
    wait_rsp(2'b01, 32'd0, "srl", lat);
    chk("srl_latency", lat, 2);
    chk("srl_zero", rsp_zero, 1'b1);
    req_op[1] = sub_op; req_valid[1] = 1'b1;
    wait_grant(2'b10, "sub");
    wait_rsp(2'b10, 32'hFFFF_FFFE, "sub", lat);
    chk("sub_zero", rsp_zero, 1'b0);

    // Backpressure; the non-owner's rsp_ready stays high throughout.
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    req_op[0] = xor_op; req_valid[0] = 1'b1;
    wait_grant(2'b01, "bp");
    req_op[1] = add12; req_valid[1] = 1'b1;
    wait_rsp(2'b01, 32'hFF, "bp", lat);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_result", rsp_result, 32'hFF);
      chk("bp_hold_ready", req_ready, 2'b00);
      chk("bp_hold_busy", busy, 1'b1);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_last_valid", rsp_valid, 2'b01);
    @(negedge clk);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_ready", req_ready, 2'b10);
    wait_grant(2'b10, "bp_next");
    wait_rsp(2'b10, 32'd3, "bp_next", lat);

    // Leave prio at req1, then reset during ISSUE of req1's op.
    req_op[0] = and_op; req_valid[0] = 1'b1;
    wait_grant(2'b01, "and");
    wait_rsp(2'b01, 32'h0F, "and", lat);
    chk("and_branch", rsp_branch, 1'b0);
    req_op[0] = add57; req_op[1] = pc_op; req_valid = 2'b11;
    wait_grant(2'b10, "pre_rst");
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_ex_rs1", ex_rs1, 0);
    req_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_grant(2'b01, "post_rst");
    wait_rsp(2'b01, 32'd12, "post_rst", lat);
    wait_grant(2'b10, "pc");
    wait_rsp(2'b10, 32'h104, "pc", lat);
    chk("pc_jalr", rsp_jalr_target, 20'h2004);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
